// File: rtl/data_assembly_register.sv
// data_assembly_register: assembles WIDTH-bit words from LANE-bit chunks with lane count and overrun flag
module data_assembly_register #(
  parameter int WIDTH = 32,
  parameter int LANE = 8,
  localparam int NLANES = WIDTH / LANE,
  localparam int CW = $clog2(NLANES + 1)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [LANE-1:0]  I,
  input  logic [2:0]       FunSel,
  input  logic             E,
  input  logic             Ack,
  output logic [WIDTH-1:0] DROut,
  output logic [CW-1:0]    Count,
  output logic             Full,
  output logic             Overrun
);
  if (WIDTH % LANE != 0 || WIDTH < 2 * LANE) begin : g_bad_params
    $error("WIDTH must be a multiple of LANE and at least 2*LANE");
  end
  logic [WIDTH-1:0] r_data, w_data;
  logic [CW-1:0]    r_count, w_count, w_base;
  logic             r_ovr, w_ovr, w_sat;
  assign w_base = Ack ? '0 : r_count;
  assign w_sat  = w_base == CW'(NLANES);
  // next-state: Ack drops the count unless the op sets it; shift-in at full saturates and flags overrun
  always_comb begin
    w_data  = r_data;
    w_count = w_base;
    w_ovr   = r_ovr;
    if (E)
      case (FunSel)
        3'b000: begin
          w_data  = {{(WIDTH-LANE){I[LANE-1]}}, I};
          w_count = CW'(1);
        end
        3'b001: begin
          w_data  = {{(WIDTH-LANE){1'b0}}, I};
          w_count = CW'(1);
        end
        3'b010: begin
          w_data  = {r_data[WIDTH-LANE-1:0], I};
          w_count = w_sat ? CW'(NLANES) : w_base + CW'(1);
          w_ovr   = r_ovr | w_sat;
        end
        3'b011: begin
          w_data  = {I, r_data[WIDTH-1:LANE]};
          w_count = w_sat ? CW'(NLANES) : w_base + CW'(1);
          w_ovr   = r_ovr | w_sat;
        end
        3'b100: w_data = {r_data[WIDTH-LANE-1:0], r_data[WIDTH-1:WIDTH-LANE]};
        3'b101: w_data = {r_data[LANE-1:0], r_data[WIDTH-1:LANE]};
        3'b110: begin
          w_data  = '0;
          w_count = '0;
          w_ovr   = 1'b0;
        end
        default: ;
      endcase
  end
  // state registers with asynchronous clear
  always_ff @(posedge Clock or posedge Reset)
    if (Reset) begin
      r_data  <= '0;
      r_count <= '0;
      r_ovr   <= 1'b0;
    end else begin
      r_data  <= w_data;
      r_count <= w_count;
      r_ovr   <= w_ovr;
    end
  assign DROut   = r_data;
  assign Count   = r_count;
  assign Full    = r_count == CW'(NLANES);
  assign Overrun = r_ovr;
endmodule

// File: tb/tb_data_assembly_register.sv
// tb_data_assembly_register: directed vectors for the 32/8 and 16/4 configurations
module tb_data_assembly_register;
  logic        Clock, Reset;
  logic [7:0]  I;
  logic [2:0]  FunSel;
  logic        E, Ack;
  logic [31:0] DROut;
  logic [2:0]  Count;
  logic        Full, Overrun;
  logic [3:0]  I2;
  logic [2:0]  FunSel2;
  logic        E2, Ack2;
  logic [15:0] DROut2;
  logic [2:0]  Count2;
  logic        Full2, Overrun2;
  int n_vec = 0;
  int n_err = 0;
  data_assembly_register #(.WIDTH(32), .LANE(8)) dut (
    .Clock(Clock), .Reset(Reset), .I(I), .FunSel(FunSel), .E(E), .Ack(Ack),
    .DROut(DROut), .Count(Count), .Full(Full), .Overrun(Overrun)
  );
  data_assembly_register #(.WIDTH(16), .LANE(4)) dut16 (
    .Clock(Clock), .Reset(Reset), .I(I2), .FunSel(FunSel2), .E(E2), .Ack(Ack2),
    .DROut(DROut2), .Count(Count2), .Full(Full2), .Overrun(Overrun2)
  );
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step(input logic [2:0] fs, input logic [7:0] d, input logic e, input logic a);
    FunSel = fs;
    I = d;
    E = e;
    Ack = a;
    @(posedge Clock);
    #1;
  endtask
  task automatic step16(input logic [2:0] fs, input logic [3:0] d);
    FunSel2 = fs;
    I2 = d;
    E2 = 1'b1;
    Ack2 = 1'b0;
    @(posedge Clock);
    #1;
  endtask
  initial begin
    Reset = 1'b1;
    {I, FunSel, E, Ack} = '0;
    {I2, FunSel2, E2, Ack2} = '0;
    #12;
    chk("rst_data", DROut, 32'h0);
    chk("rst_count", 32'(Count), 32'd0);
    chk("rst_full", 32'(Full), 32'd0);
    chk("rst_ovr", 32'(Overrun), 32'd0);
    Reset = 1'b0;
    @(posedge Clock);
    #1;
    step(3'b001, 8'h11, 1, 0);
    step(3'b010, 8'h22, 1, 0);
    step(3'b010, 8'h33, 1, 0);
    step(3'b010, 8'h44, 1, 0);
    step(3'b010, 8'h55, 1, 0);
    chk("pre_arst_ovr", 32'(Overrun), 32'd1);
    E = 1'b0;
    #2 Reset = 1'b1;
    #1;
    chk("arst_data", DROut, 32'h0);
    chk("arst_count", 32'(Count), 32'd0);
    chk("arst_full", 32'(Full), 32'd0);
    chk("arst_ovr", 32'(Overrun), 32'd0);
    Reset = 1'b0;
    step(3'b000, 8'h85, 1, 0);
    chk("sext_data", DROut, 32'hFFFFFF85);
    chk("sext_count", 32'(Count), 32'd1);
    step(3'b001, 8'h85, 1, 0);
    chk("zext_data", DROut, 32'h00000085);
    chk("zext_count", 32'(Count), 32'd1);
    step(3'b001, 8'h11, 1, 0);
    step(3'b010, 8'h22, 1, 0);
    step(3'b010, 8'h33, 1, 0);
    step(3'b010, 8'h44, 1, 0);
    chk("asm_data", DROut, 32'h11223344);
    chk("asm_count", 32'(Count), 32'd4);
    chk("asm_full", 32'(Full), 32'd1);
    chk("asm_ovr", 32'(Overrun), 32'd0);
    step(3'b010, 8'h55, 1, 0);
    chk("ovf_data", DROut, 32'h22334455);
    chk("ovf_count", 32'(Count), 32'd4);
    chk("ovf_ovr", 32'(Overrun), 32'd1);
    step(3'b110, 8'h00, 1, 0);
    step(3'b001, 8'h11, 1, 0);
    step(3'b010, 8'h22, 1, 0);
    step(3'b010, 8'h33, 1, 0);
    step(3'b010, 8'h44, 1, 0);
    step(3'b100, 8'h00, 1, 0);
    chk("rotl_data", DROut, 32'h22334411);
    step(3'b101, 8'h00, 1, 0);
    chk("rotr_data", DROut, 32'h11223344);
    chk("rotr_count", 32'(Count), 32'd4);
    step(3'b011, 8'hAA, 1, 1);
    chk("shr_ack_data", DROut, 32'hAA112233);
    chk("shr_ack_count", 32'(Count), 32'd1);
    chk("shr_ack_ovr", 32'(Overrun), 32'd0);
    step(3'b010, 8'h01, 1, 0);
    step(3'b010, 8'h02, 1, 0);
    chk("part_data", DROut, 32'h22330102);
    chk("part_count", 32'(Count), 32'd3);
    step(3'b000, 8'hFF, 0, 0);
    chk("hold_data", DROut, 32'h22330102);
    chk("hold_count", 32'(Count), 32'd3);
    step(3'b000, 8'hFF, 0, 1);
    chk("eack_count", 32'(Count), 32'd0);
    chk("eack_data", DROut, 32'h22330102);
    step(3'b010, 8'h03, 1, 0);
    step(3'b010, 8'h04, 1, 0);
    step(3'b010, 8'h05, 1, 0);
    step(3'b010, 8'h06, 1, 0);
    step(3'b010, 8'h07, 1, 0);
    chk("ovf2_data", DROut, 32'h04050607);
    chk("ovf2_ovr", 32'(Overrun), 32'd1);
    step(3'b001, 8'h5A, 1, 1);
    chk("ackld_data", DROut, 32'h0000005A);
    chk("ackld_count", 32'(Count), 32'd1);
    chk("ld_keeps_ovr", 32'(Overrun), 32'd1);
    step(3'b110, 8'h00, 1, 0);
    chk("clr_data", DROut, 32'h0);
    chk("clr_count", 32'(Count), 32'd0);
    chk("clr_ovr", 32'(Overrun), 32'd0);
    chk("clr_full", 32'(Full), 32'd0);
    step16(3'b001, 4'hA);
    step16(3'b010, 4'hB);
    step16(3'b010, 4'hC);
    step16(3'b010, 4'hD);
    chk("w16_data", 32'(DROut2), 32'h0000ABCD);
    chk("w16_count", 32'(Count2), 32'd4);
    chk("w16_full", 32'(Full2), 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
